// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud limits.
// The transmitter will reuse these as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    localparam int UartMinBaudCyc = 4;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// ResetVal selects the idle level the flops hold while in reset.
module uart_sync2 #(
    parameter int               Width    = 1,
    parameter logic [Width-1:0] ResetVal = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: frames LSB-first data bits into a one-entry
// valid/ready buffer, flagging stop-bit errors and buffer overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BaudCycBits = 16,
    parameter int DataBits    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx,
    input  logic [BaudCycBits-1:0] i_baud_cyc,
    output logic                   o_busy,
    output logic [DataBits-1:0]    o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_overrun
);

    localparam int                     IdxBits = (DataBits > 1) ? $clog2(DataBits) : 1;
    localparam logic [BaudCycBits-1:0] MinBaud = BaudCycBits'(UartMinBaudCyc);
    localparam logic [BaudCycBits-1:0] CntOne  = BaudCycBits'(1);
    localparam logic [IdxBits-1:0]     LastIdx = IdxBits'(DataBits - 1);
    localparam logic [IdxBits-1:0]     IdxOne  = IdxBits'(1);

    logic rx_s;

    uart_sync2 #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    uart_rx_state_e           state_q, state_d;
    logic [BaudCycBits-1:0]   cnt_q, cnt_d;
    logic [BaudCycBits-1:0]   baud_q, baud_d;
    logic [IdxBits-1:0]       idx_q, idx_d;
    logic [DataBits-1:0]      shift_q, shift_d;
    logic [DataBits-1:0]      data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     ovr_q, ovr_d;
    logic                     deliver;
    logic                     cnt_exp;
    logic [BaudCycBits-1:0]   baud_clamped;

    assign cnt_exp      = (cnt_q == CntOne);
    assign baud_clamped = (i_baud_cyc < MinBaud) ? MinBaud : i_baud_cyc;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? (cnt_q - CntOne) : cnt_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        // Baud count is captured once per frame so config changes only apply between frames
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    baud_d  = baud_clamped;
                    cnt_d   = baud_clamped >> 1;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_exp) begin
                    if (!rx_s) begin
                        cnt_d   = baud_q;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_exp) begin
                    shift_d              = shift_q >> 1;
                    shift_d[DataBits-1]  = rx_s;
                    cnt_d                = baud_q;
                    if (idx_q == LastIdx) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
            end
            STOP: begin
                if (cnt_exp) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte completing on a handshake cycle replaces the drained one
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are driven bit by bit and outputs are
// compared against hand-computed cycle positions relative to the start edge.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rx;
    logic [15:0] baudCyc;
    logic        busy;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frameErr;
    logic        overrun;

    int assertions = 0;
    int failures   = 0;

    int         hsCount   = 0;
    int         ferrCount = 0;
    int         ovrCount  = 0;
    logic [7:0] lastHsData = 8'h00;

    int hs0;
    int ferr0;
    int ovr0;

    uart_rx #(
        .BaudCycBits (16),
        .DataBits    (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_rx        (rx),
        .i_baud_cyc  (baudCyc),
        .o_busy      (busy),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frameErr),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Event monitors sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (valid && ready) begin
            hsCount    = hsCount + 1;
            lastHsData = data;
        end
        if (frameErr) ferrCount = ferrCount + 1;
        if (overrun)  ovrCount  = ovrCount + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions = assertions + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one frame starting in the current cycle; the stop level is held stopLen cycles
    task automatic applyStimulus(input logic [7:0] byteVal, input int baud, input logic stopVal, input int stopLen);
        rx = 1'b0;
        tick(baud);
        for (int k = 0; k < 8; k++) begin
            rx = byteVal[k];
            tick(baud);
        end
        rx = stopVal;
        tick(stopLen);
        rx = 1'b1;
    endtask

    initial begin
        rstN    = 1'b0;
        rx      = 1'b1;
        baudCyc = 16'd16;
        ready   = 1'b1;
        tick(3);

        checkOutput("rst_busy",  32'(busy),     32'd0);
        checkOutput("rst_valid", 32'(valid),    32'd0);
        checkOutput("rst_data",  32'(data),     32'd0);
        checkOutput("rst_ferr",  32'(frameErr), 32'd0);
        checkOutput("rst_ovr",   32'(overrun),  32'd0);

        rstN = 1'b1;
        tick(5);

        $display("[TB] basic byte 0xA5");
        hs0 = hsCount;
        fork
            applyStimulus(8'hA5, 16, 1'b1, 16);
            begin
                tick(2);
                checkOutput("basic_busy_t2", 32'(busy), 32'd0);
                tick(1);
                checkOutput("basic_busy_t3", 32'(busy), 32'd1);
                tick(151);
                checkOutput("basic_busy_t154",  32'(busy),  32'd1);
                checkOutput("basic_valid_t154", 32'(valid), 32'd0);
                tick(1);
                checkOutput("basic_busy_t155",  32'(busy),  32'd0);
                checkOutput("basic_valid_t155", 32'(valid), 32'd1);
                checkOutput("basic_data_t155",  32'(data),  32'hA5);
            end
        join
        checkOutput("basic_drained", 32'(valid), 32'd0);
        checkOutput("basic_hs_count", 32'(hsCount - hs0), 32'd1);
        checkOutput("basic_hs_data", 32'(lastHsData), 32'hA5);
        tick(10);

        $display("[TB] short glitch");
        hs0   = hsCount;
        ferr0 = ferrCount;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(1);
        checkOutput("glitch_busy_t5", 32'(busy), 32'd1);
        tick(7);
        checkOutput("glitch_busy_t12", 32'(busy), 32'd0);
        tick(20);
        checkOutput("glitch_no_valid", 32'(hsCount - hs0), 32'd0);
        checkOutput("glitch_no_ferr", 32'(ferrCount - ferr0), 32'd0);

        $display("[TB] frame error 0x3C");
        hs0   = hsCount;
        ferr0 = ferrCount;
        fork
            applyStimulus(8'h3C, 16, 1'b0, 56);
            begin
                tick(155);
                checkOutput("ferr_pulse_t155", 32'(frameErr), 32'd1);
                checkOutput("ferr_valid_t155", 32'(valid),    32'd0);
                checkOutput("ferr_busy_t155",  32'(busy),     32'd1);
                tick(1);
                checkOutput("ferr_pulse_t156", 32'(frameErr), 32'd0);
            end
        join
        tick(2);
        checkOutput("ferr_busy_h2", 32'(busy), 32'd1);
        tick(1);
        checkOutput("ferr_busy_h3", 32'(busy), 32'd0);
        checkOutput("ferr_count", 32'(ferrCount - ferr0), 32'd1);
        checkOutput("ferr_no_valid", 32'(hsCount - hs0), 32'd0);
        tick(10);

        $display("[TB] overrun 0x11 then 0x22");
        hs0   = hsCount;
        ovr0  = ovrCount;
        ready = 1'b0;
        fork
            begin
                applyStimulus(8'h11, 16, 1'b1, 16);
                applyStimulus(8'h22, 16, 1'b1, 16);
            end
            begin
                tick(315);
                checkOutput("ovr_pulse_t315", 32'(overrun), 32'd1);
                checkOutput("ovr_valid_t315", 32'(valid),   32'd1);
                checkOutput("ovr_data_t315",  32'(data),    32'h11);
                tick(1);
                checkOutput("ovr_pulse_t316", 32'(overrun), 32'd0);
            end
        join
        checkOutput("ovr_count", 32'(ovrCount - ovr0), 32'd1);
        ready = 1'b1;
        tick(1);
        checkOutput("ovr_drained", 32'(valid), 32'd0);
        checkOutput("ovr_hs_data", 32'(lastHsData), 32'h11);
        tick(20);
        checkOutput("ovr_hs_count", 32'(hsCount - hs0), 32'd1);
        checkOutput("ovr_still_empty", 32'(valid), 32'd0);

        $display("[TB] baud change mid-frame");
        fork
            applyStimulus(8'h5A, 16, 1'b1, 16);
            begin
                tick(50);
                baudCyc = 16'd32;
                tick(105);
                checkOutput("baud_valid_t155", 32'(valid), 32'd1);
                checkOutput("baud_data_t155",  32'(data),  32'h5A);
            end
        join
        fork
            applyStimulus(8'h96, 32, 1'b1, 32);
            begin
                tick(306);
                checkOutput("baud32_valid_t306", 32'(valid), 32'd0);
                tick(1);
                checkOutput("baud32_valid_t307", 32'(valid), 32'd1);
                checkOutput("baud32_data_t307",  32'(data),  32'h96);
            end
        join
        tick(10);

        $display("[TB] baud below minimum clamps to 4");
        baudCyc = 16'd2;
        fork
            applyStimulus(8'h69, 4, 1'b1, 4);
            begin
                tick(40);
                checkOutput("clamp_valid_t40", 32'(valid), 32'd0);
                tick(1);
                checkOutput("clamp_valid_t41", 32'(valid), 32'd1);
                checkOutput("clamp_data_t41",  32'(data),  32'h69);
            end
        join
        tick(10);
        baudCyc = 16'd16;

        $display("[TB] reset mid-frame");
        rx = 1'b0;
        tick(40);
        rstN = 1'b0;
        tick(1);
        rstN = 1'b1;
        rx   = 1'b1;
        checkOutput("midrst_busy",  32'(busy),     32'd0);
        checkOutput("midrst_valid", 32'(valid),    32'd0);
        checkOutput("midrst_data",  32'(data),     32'd0);
        checkOutput("midrst_ferr",  32'(frameErr), 32'd0);
        checkOutput("midrst_ovr",   32'(overrun),  32'd0);
        tick(40);
        checkOutput("midrst_idle", 32'(busy), 32'd0);
        fork
            applyStimulus(8'hC3, 16, 1'b1, 16);
            begin
                tick(155);
                checkOutput("after_rst_valid", 32'(valid), 32'd1);
                checkOutput("after_rst_data",  32'(data),  32'hC3);
            end
        join
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
